// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake,
// buffers them with their PCs in a prefetch FIFO and presents the head as IR.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        br_en,
  input  logic [31:0] br_target
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        fifo_q [FIFO_DEPTH];

  logic          push, pop;
  logic [CW-1:0] cnt_after;
  logic [31:0]   br_pc;
  entry_t        head;

  assign br_pc     = {br_target[31:2], 2'b00};
  // A redirect wins over both a same-cycle push and a same-cycle pop.
  assign push      = (state_q == REQ) && imem_ack && !br_en;
  assign pop       = (count_q != '0) && ir_ready && !br_en;
  assign cnt_after = count_q + CW'(push) - CW'(pop);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: the outstanding request reserves a FIFO slot, so an
  // ack can never meet a full FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (br_en || (count_q < DEPTH_C)) state_d = REQ;
      REQ: begin
        if (imem_ack)   state_d = (br_en || (cnt_after < DEPTH_C)) ? REQ : IDLE;
        else if (br_en) state_d = DRAIN;
      end
      DRAIN:   if (imem_ack) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    head      = fifo_q[rd_ptr_q];
    imem_req  = (state_q != IDLE);
    imem_addr = addr_q;
    ir_valid  = (count_q != '0);
    IR        = ir_valid ? head.ins : 32'h0;
    ir_pc     = ir_valid ? head.pc  : 32'h0;
  end

  // Datapath: pc_q is the next address to fetch, addr_q the address on the
  // bus. They only differ while draining a request abandoned by a redirect.
  always_comb begin
    pc_d     = pc_q;
    addr_d   = addr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (br_en) begin
      pc_d     = br_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if ((state_q == IDLE) || imem_ack) addr_d = br_pc;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = cnt_after;
      if (push) begin
        pc_d   = pc_q + 32'd4;
        addr_d = pc_q + 32'd4;
      end
      if ((state_q == DRAIN) && imem_ack) addr_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{ins: imem_rdata, pc: addr_q};
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed table-driven bench for inst_fetch: one DUT at RESET_PC=0 and one at
// 0xFFFF_FFF8 share stimulus; memory returns ~address as the fetched word.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic        ir_ready = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_target = 32'h0;

  logic        lo_req, hi_req, lo_vld, hi_vld;
  logic [31:0] lo_addr, hi_addr, lo_rdata, hi_rdata;
  logic [31:0] lo_ir, hi_ir, lo_pc, hi_pc;

  int checks = 0;
  int errors = 0;

  assign lo_rdata = ~lo_addr;
  assign hi_rdata = ~hi_addr;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_lo (
    .clk(clk), .rst(rst),
    .imem_req(lo_req), .imem_addr(lo_addr), .imem_ack(imem_ack), .imem_rdata(lo_rdata),
    .IR(lo_ir), .ir_pc(lo_pc), .ir_valid(lo_vld), .ir_ready(ir_ready),
    .br_en(br_en), .br_target(br_target)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_hi (
    .clk(clk), .rst(rst),
    .imem_req(hi_req), .imem_addr(hi_addr), .imem_ack(imem_ack), .imem_rdata(hi_rdata),
    .IR(hi_ir), .ir_pc(hi_pc), .ir_valid(hi_vld), .ir_ready(ir_ready),
    .br_en(br_en), .br_target(br_target)
  );

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ir;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tv_lo[$];
  vec_t tv_hi[$];

  function automatic vec_t mk(input logic ack, input logic rdy, input logic br,
                              input logic [31:0] tgt, input logic req,
                              input logic [31:0] addr, input logic vld,
                              input logic [31:0] ir, input logic [31:0] pc);
    vec_t v;
    v.ack = ack; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_ir = ir; v.e_pc = pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input bit sel, input vec_t v);
    chk({nm, " req"},  32'(sel ? hi_req  : lo_req),  32'(v.e_req));
    chk({nm, " addr"},     sel ? hi_addr : lo_addr,      v.e_addr);
    chk({nm, " vld"},  32'(sel ? hi_vld  : lo_vld),  32'(v.e_vld));
    chk({nm, " IR"},       sel ? hi_ir   : lo_ir,        v.e_ir);
    chk({nm, " pc"},       sel ? hi_pc   : lo_pc,        v.e_pc);
  endtask

  // Called at a negedge: drive the cycle's inputs, check state-derived outputs.
  task automatic run_vec(input vec_t v, input bit sel, input string nm);
    imem_ack  = v.ack;
    ir_ready  = v.rdy;
    br_en     = v.br;
    br_target = v.tgt;
    #1;
    chk_outs(nm, sel, v);
    @(negedge clk);
  endtask

  initial begin
    // T1 stream, T2 fill/stall, T3 slow ack, T4 redirect while pending,
    // T5 redirect+pop+ack together, then redirects while draining.
    tv_lo.push_back(mk(1,1,0,32'h0,   0,32'h00,  0,32'h0,        32'h0));
    tv_lo.push_back(mk(1,1,0,32'h0,   1,32'h00,  0,32'h0,        32'h0));
    tv_lo.push_back(mk(1,1,0,32'h0,   1,32'h04,  1,32'hFFFFFFFF, 32'h0));
    tv_lo.push_back(mk(1,1,0,32'h0,   1,32'h08,  1,32'hFFFFFFFB, 32'h4));
    tv_lo.push_back(mk(1,0,0,32'h0,   1,32'h0C,  1,32'hFFFFFFF7, 32'h8));
    tv_lo.push_back(mk(1,0,0,32'h0,   0,32'h10,  1,32'hFFFFFFF7, 32'h8));
    tv_lo.push_back(mk(1,0,0,32'h0,   0,32'h10,  1,32'hFFFFFFF7, 32'h8));
    tv_lo.push_back(mk(1,1,0,32'h0,   0,32'h10,  1,32'hFFFFFFF7, 32'h8));
    tv_lo.push_back(mk(1,1,0,32'h0,   0,32'h10,  1,32'hFFFFFFF3, 32'hC));
    tv_lo.push_back(mk(0,0,0,32'h0,   1,32'h10,  0,32'h0,        32'h0));
    tv_lo.push_back(mk(0,0,0,32'h0,   1,32'h10,  0,32'h0,        32'h0));
    tv_lo.push_back(mk(0,0,0,32'h0,   1,32'h10,  0,32'h0,        32'h0));
    tv_lo.push_back(mk(1,0,0,32'h0,   1,32'h10,  0,32'h0,        32'h0));
    tv_lo.push_back(mk(0,0,0,32'h0,   1,32'h14,  1,32'hFFFFFFEF, 32'h10));
    tv_lo.push_back(mk(0,0,0,32'h0,   1,32'h14,  1,32'hFFFFFFEF, 32'h10));
    tv_lo.push_back(mk(0,0,1,32'h107, 1,32'h14,  1,32'hFFFFFFEF, 32'h10));
    tv_lo.push_back(mk(0,0,0,32'h0,   1,32'h14,  0,32'h0,        32'h0));
    tv_lo.push_back(mk(1,0,0,32'h0,   1,32'h14,  0,32'h0,        32'h0));
    tv_lo.push_back(mk(1,1,0,32'h0,   1,32'h104, 0,32'h0,        32'h0));
    tv_lo.push_back(mk(1,1,1,32'h200, 1,32'h108, 1,32'hFFFFFEFB, 32'h104));
    tv_lo.push_back(mk(0,1,0,32'h0,   1,32'h200, 0,32'h0,        32'h0));
    tv_lo.push_back(mk(0,0,1,32'h300, 1,32'h200, 0,32'h0,        32'h0));
    tv_lo.push_back(mk(0,0,1,32'h402, 1,32'h200, 0,32'h0,        32'h0));
    tv_lo.push_back(mk(1,0,0,32'h0,   1,32'h200, 0,32'h0,        32'h0));
    tv_lo.push_back(mk(0,0,0,32'h0,   1,32'h400, 0,32'h0,        32'h0));

    // T6: PC wraps through the top of the address space.
    tv_hi.push_back(mk(1,1,0,32'h0, 0,32'hFFFFFFF8, 0,32'h0,        32'h0));
    tv_hi.push_back(mk(1,1,0,32'h0, 1,32'hFFFFFFF8, 0,32'h0,        32'h0));
    tv_hi.push_back(mk(1,1,0,32'h0, 1,32'hFFFFFFFC, 1,32'h00000007, 32'hFFFFFFF8));
    tv_hi.push_back(mk(1,1,0,32'h0, 1,32'h00000000, 1,32'h00000003, 32'hFFFFFFFC));
    tv_hi.push_back(mk(1,1,0,32'h0, 1,32'h00000004, 1,32'hFFFFFFFF, 32'h00000000));
    tv_hi.push_back(mk(0,1,0,32'h0, 1,32'h00000008, 1,32'hFFFFFFFB, 32'h00000004));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_outs("reset", 1'b0, mk(0,0,0,32'h0, 0,32'h0, 0,32'h0, 32'h0));
    chk("reset hi addr", hi_addr, 32'hFFFFFFF8);

    rst = 1'b0;
    for (int i = 0; i < tv_lo.size(); i++) run_vec(tv_lo[i], 1'b0, $sformatf("lo c%0d", i));

    rst = 1'b1;
    imem_ack = 1'b0; ir_ready = 1'b0; br_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tv_hi.size(); i++) run_vec(tv_hi[i], 1'b1, $sformatf("hi c%0d", i));

    // Asynchronous reset mid-wait, then a late ack while coming out of reset.
    imem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_outs("hi async rst", 1'b1, mk(0,0,0,32'h0, 0,32'hFFFFFFF8, 0,32'h0, 32'h0));
    imem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(1,1,0,32'h0, 0,32'hFFFFFFF8, 0,32'h0, 32'h0), 1'b1, "hi post-rst c0");
    run_vec(mk(1,1,0,32'h0, 1,32'hFFFFFFF8, 0,32'h0, 32'h0), 1'b1, "hi post-rst c1");
    run_vec(mk(0,0,0,32'h0, 1,32'hFFFFFFFC, 1,32'h00000007, 32'hFFFFFFF8), 1'b1, "hi post-rst c2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
